// File: rtl/utils_pkg.sv
// Shared word type and Gray/binary conversion helpers for the dual-clock FIFO controllers.
package utils_pkg;

  localparam int unsigned WordWidth   = 8;
  localparam int unsigned MaxPtrWidth = WordWidth;

  typedef logic [WordWidth-1:0] word_t;
  typedef logic [WordWidth-1:0] gray_ptr_t;

  function automatic word_t bin_to_gray(input word_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic word_t gray_to_bin(input word_t g);
    word_t b;
    b[WordWidth-1] = g[WordWidth-1];
    for (int i = WordWidth - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_ptr_sync.sv
// Multi-flop synchroniser for a Gray-coded pointer crossing into the local clock domain.
module gray_ptr_sync
  import utils_pkg::*;
#(
  parameter int unsigned SyncStages = 2
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  gray_ptr_t ptr_gray_i,
  output gray_ptr_t ptr_gray_o
);

  gray_ptr_t r_sync [SyncStages];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < SyncStages; i++) r_sync[i] <= '0;
    end else begin
      r_sync[0] <= ptr_gray_i;
      for (int i = 1; i < SyncStages; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  assign ptr_gray_o = r_sync[SyncStages-1];

endmodule

// File: rtl/async_fifo_rd_ctrl.sv
// Read-side controller of a dual-clock FIFO: pointer sync, RAM fetch and valid/ready output stage.
// Optional registered fill level on level_o when ASYNC_FIFO_RD_LEVEL_EN is defined.
module async_fifo_rd_ctrl
  import utils_pkg::*;
#(
  parameter int unsigned AddrWidth  = 4,
  parameter int unsigned DataWidth  = 8,
  parameter int unsigned SyncStages = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  gray_ptr_t            wr_ptr_gray_i,
  output gray_ptr_t            rd_ptr_gray_o,
  output logic                 mem_ren_o,
  output logic [AddrWidth-1:0] mem_raddr_o,
  input  logic [DataWidth-1:0] mem_rdata_i,
  output logic [DataWidth-1:0] data_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 empty_o
`ifdef ASYNC_FIFO_RD_LEVEL_EN
  , output logic [AddrWidth:0] level_o
`endif
);

  localparam int unsigned PtrW = AddrWidth + 1;

  if ((AddrWidth + 1 > MaxPtrWidth) || (SyncStages < 2)) begin : g_param_check
    $fatal(1, "async_fifo_rd_ctrl: AddrWidth+1 must be <= %0d and SyncStages >= 2", MaxPtrWidth);
  end

  gray_ptr_t       w_wr_gray_sync;
  word_t           w_wr_bin;
  logic            w_unused;
  logic            w_ram_empty;
  logic            w_fetch;
  logic [PtrW-1:0] w_rd_ptr_nxt;
  logic [PtrW-1:0] r_rd_ptr;
  gray_ptr_t       r_rd_gray;
  logic            r_valid;

  gray_ptr_sync #(
    .SyncStages(SyncStages)
  ) u_wr_ptr_sync (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .ptr_gray_i (wr_ptr_gray_i),
    .ptr_gray_o (w_wr_gray_sync)
  );

  assign w_wr_bin     = gray_to_bin(w_wr_gray_sync);
  assign w_unused     = ^w_wr_bin;
  assign w_ram_empty  = (w_wr_bin[PtrW-1:0] == r_rd_ptr);
  // Fetch whenever the output register is free or being drained this cycle.
  assign w_fetch      = !w_ram_empty && (!r_valid || ready_i);
  assign w_rd_ptr_nxt = r_rd_ptr + {{(PtrW-1){1'b0}}, 1'b1};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rd_ptr  <= '0;
      r_rd_gray <= '0;
      r_valid   <= 1'b0;
    end else begin
      if (w_fetch) begin
        r_rd_ptr  <= w_rd_ptr_nxt;
        r_rd_gray <= bin_to_gray(word_t'(w_rd_ptr_nxt));
        r_valid   <= 1'b1;
      end else if (ready_i) begin
        r_valid   <= 1'b0;
      end
    end
  end

`ifdef ASYNC_FIFO_RD_LEVEL_EN
  logic [PtrW-1:0] w_level_nxt;
  logic [PtrW-1:0] r_level;

  assign w_level_nxt = w_wr_bin[PtrW-1:0] - r_rd_ptr;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_level <= '0;
    else         r_level <= w_level_nxt;
  end

  assign level_o = r_level;
`endif

  assign rd_ptr_gray_o = r_rd_gray;
  assign mem_ren_o     = w_fetch;
  assign mem_raddr_o   = r_rd_ptr[AddrWidth-1:0];
  assign data_o        = mem_rdata_i;
  assign valid_o       = r_valid;
  assign empty_o       = !r_valid;

endmodule

// File: tb/tb_async_fifo_rd_ctrl.sv
// Self-checking bench for async_fifo_rd_ctrl: queue-based reference model with randomized traffic.
module tb_async_fifo_rd_ctrl;
  import utils_pkg::*;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int SS = 2;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  gray_ptr_t     wr_ptr_gray_i;
  gray_ptr_t     rd_ptr_gray_o;
  logic          mem_ren_o;
  logic [AW-1:0] mem_raddr_o;
  logic [DW-1:0] mem_rdata_i;
  logic [DW-1:0] data_o;
  logic          valid_o;
  logic          ready_i;
  logic          empty_o;
`ifdef ASYNC_FIFO_RD_LEVEL_EN
  logic [AW:0]   level_o;
`endif

  async_fifo_rd_ctrl #(.AddrWidth(AW), .DataWidth(DW), .SyncStages(SS)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .wr_ptr_gray_i (wr_ptr_gray_i),
    .rd_ptr_gray_o (rd_ptr_gray_o),
    .mem_ren_o     (mem_ren_o),
    .mem_raddr_o   (mem_raddr_o),
    .mem_rdata_i   (mem_rdata_i),
    .data_o        (data_o),
    .valid_o       (valid_o),
    .ready_i       (ready_i),
    .empty_o       (empty_o)
`ifdef ASYNC_FIFO_RD_LEVEL_EN
    , .level_o     (level_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  logic [DW-1:0] mem [16];
  always @(posedge clk_i) if (mem_ren_o) mem_rdata_i <= mem[mem_raddr_o];

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int consumed = 0;
  int cyc = 0;
  logic [DW-1:0] exp_q [$];
  logic [7:0] prev_gray = 8'h00;
  bit wrap_seen = 0;

  function automatic logic [7:0] b2g(input int n);
    logic [7:0] b;
    b = 8'(n % 32);
    return b ^ (b >> 1);
  endfunction

  function automatic int g2b(input logic [7:0] g);
    int b = 0;
    for (int i = 7; i >= 0; i--) b = (b << 1) | (((b & 1) ^ int'(g[i])) & 1);
    return b;
  endfunction

  function automatic int space();
    return 16 - (((wr_cnt % 32) - g2b(rd_ptr_gray_o) + 32) % 32);
  endfunction

  task automatic write_word(input logic [DW-1:0] d);
    mem[wr_cnt % 16] = d;
    wr_cnt++;
    wr_ptr_gray_i = b2g(wr_cnt);
    exp_q.push_back(d);
  endtask

  task automatic model_reset();
    wr_cnt = 0;
    consumed = 0;
    exp_q.delete();
    wr_ptr_gray_i = '0;
    prev_gray = 8'h00;
  endtask

  // One read-clock cycle: drive ready at the falling edge, then check the stream rules.
  task automatic tick(input logic rdy);
    logic [7:0] eg;
    logic [DW-1:0] ed;
    @(negedge clk_i);
    ready_i = rdy;
    cyc++;
    #1;
    checks++;
    if (empty_o !== !valid_o) begin
      errors++; $display("FAIL empty_vs_valid: empty_o=%b valid_o=%b", empty_o, valid_o);
    end
    eg = b2g(consumed + int'(valid_o));
    checks++;
    if (rd_ptr_gray_o !== eg) begin
      errors++; $display("FAIL rd_gray: got %h expected %h", rd_ptr_gray_o, eg);
    end
    checks++;
    if (valid_o && !ready_i && mem_ren_o !== 1'b0) begin
      errors++; $display("FAIL ren_backpressure: mem_ren_o=%b expected 0", mem_ren_o);
    end
    if (rd_ptr_gray_o !== prev_gray) begin
      checks++;
      if ($countones(rd_ptr_gray_o ^ prev_gray) != 1) begin
        errors++; $display("FAIL gray_step: %h -> %h expected one bit change", prev_gray, rd_ptr_gray_o);
      end
      if (prev_gray == 8'h10 && rd_ptr_gray_o == 8'h00) wrap_seen = 1;
      prev_gray = rd_ptr_gray_o;
    end
    if (valid_o && ready_i) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++; $display("FAIL extra_word: got %h expected none", data_o);
      end else begin
        ed = exp_q.pop_front();
        if (data_o !== ed) begin
          errors++; $display("FAIL data_order: got %h expected %h", data_o, ed);
        end
      end
      consumed++;
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; ready_i = 1'b0;
    model_reset();
    repeat (3) @(negedge clk_i);
    #1 rst_ni = 1'b1;
    repeat (3) tick(1'b0);
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid_o); end
    checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", empty_o); end
    checks++; if (mem_ren_o !== 1'b0) begin errors++; $display("FAIL reset_ren: got %b expected 0", mem_ren_o); end
    checks++; if (rd_ptr_gray_o !== 8'h00) begin errors++; $display("FAIL reset_gray: got %h expected 00", rd_ptr_gray_o); end
  endtask

  task automatic test_first_word();
    write_word(8'hA5);
    tick(1'b0);
    checks++; if (mem_ren_o !== 1'b0) begin errors++; $display("FAIL first_ren_early: got %b expected 0", mem_ren_o); end
    tick(1'b0);
    checks++; if (mem_ren_o !== 1'b1) begin errors++; $display("FAIL first_ren: got %b expected 1", mem_ren_o); end
    checks++; if (mem_raddr_o !== 4'd0) begin errors++; $display("FAIL first_raddr: got %h expected 0", mem_raddr_o); end
    tick(1'b0);
    checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL first_valid: got %b expected 1", valid_o); end
    checks++; if (rd_ptr_gray_o !== 8'h01) begin errors++; $display("FAIL first_gray: got %h expected 01", rd_ptr_gray_o); end
    for (int i = 0; i < 5; i++) begin
      tick(1'b0);
      checks++;
      if (valid_o !== 1'b1 || data_o !== 8'hA5) begin
        errors++; $display("FAIL first_hold: valid=%b data=%h expected 1/a5", valid_o, data_o);
      end
    end
    tick(1'b1);
    tick(1'b0);
    checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL first_drained: empty=%b expected 1", empty_o); end
  endtask

  task automatic test_stream();
    int first = -1;
    int last = -1;
    int n = 0;
    for (int i = 0; i < 16; i++) write_word(8'($urandom));
    for (int k = 0; k < 60 && n < 16; k++) begin
      tick(1'b1);
      if (valid_o) begin
        if (first < 0) first = cyc;
        last = cyc;
        n++;
      end
    end
    checks++; if (n != 16) begin errors++; $display("FAIL stream_count: got %0d expected 16", n); end
    checks++; if (last - first != 15) begin errors++; $display("FAIL stream_rate: span %0d expected 15", last - first); end
    tick(1'b1);
    checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL stream_empty: got %b expected 1", empty_o); end
  endtask

  task automatic test_backpressure();
    logic [3:0] pat;
    int k = 0;
    pat = 4'b1001;
    for (int i = 0; i < 6; i++) write_word(8'($urandom));
    while ((exp_q.size() > 0 || valid_o) && k < 200) begin
      tick(pat[3 - (k % 4)]);
      k++;
    end
    checks++; if (k >= 200) begin errors++; $display("FAIL bp_timeout: left %0d expected 0", exp_q.size()); end
    checks++; if (consumed != 23) begin errors++; $display("FAIL bp_total: got %0d expected 23", consumed); end
  endtask

  task automatic test_wrap();
    int written = 0;
    int k = 0;
    int burst;
    while ((written < 40 || exp_q.size() > 0 || valid_o) && k < 3000) begin
      if (written < 40 && space() > 0 && $urandom_range(0, 2) != 0) begin
        burst = $urandom_range(1, 6);
        if (burst > space()) burst = space();
        if (burst > 40 - written) burst = 40 - written;
        for (int i = 0; i < burst; i++) write_word(8'($urandom));
        written += burst;
      end
      tick($urandom_range(0, 3) != 0);
      k++;
    end
    checks++; if (k >= 3000) begin errors++; $display("FAIL wrap_timeout: left %0d expected 0", exp_q.size()); end
    checks++; if (wrap_seen !== 1'b1) begin errors++; $display("FAIL wrap_gray: seen %b expected 1", wrap_seen); end
    checks++; if (consumed != 63) begin errors++; $display("FAIL wrap_total: got %0d expected 63", consumed); end
  endtask

  task automatic test_reset_midstream();
    for (int i = 0; i < 3; i++) write_word(8'($urandom));
    repeat (4) tick(1'b0);
    rst_ni = 1'b0;
    #2;
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b expected 0", valid_o); end
    checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL mid_empty: got %b expected 1", empty_o); end
    checks++; if (mem_ren_o !== 1'b0) begin errors++; $display("FAIL mid_ren: got %b expected 0", mem_ren_o); end
    checks++; if (rd_ptr_gray_o !== 8'h00) begin errors++; $display("FAIL mid_gray: got %h expected 00", rd_ptr_gray_o); end
    model_reset();
    repeat (2) @(negedge clk_i);
    #1 rst_ni = 1'b1;
    repeat (4) tick(1'b0);
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL mid_restart: valid=%b expected 0", valid_o); end
  endtask

`ifdef ASYNC_FIFO_RD_LEVEL_EN
  task automatic test_level();
    bit saw16 = 0;
    for (int i = 0; i < 16; i++) write_word(8'($urandom));
    repeat (6) begin
      tick(1'b0);
      if (level_o == 5'd16) saw16 = 1;
    end
    checks++; if (saw16 !== 1'b1) begin errors++; $display("FAIL level_16: seen %b expected 1", saw16); end
    checks++; if (level_o !== 5'd15) begin errors++; $display("FAIL level_idle: got %0d expected 15", level_o); end
    repeat (4) tick(1'b1);
    repeat (3) tick(1'b0);
    checks++; if (level_o !== 5'd11) begin errors++; $display("FAIL level_after4: got %0d expected 11", level_o); end
    while (exp_q.size() > 0 && cyc < 90000) tick(1'b1);
  endtask
`endif

  initial begin
    test_reset();
    test_first_word();
    test_stream();
    test_backpressure();
    test_wrap();
    test_reset_midstream();
`ifdef ASYNC_FIFO_RD_LEVEL_EN
    test_level();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
